// File: rtl/rotate_pkg.sv
// Shared constants, FSM state type and fixed-point helpers for the polar-to-rectangular
// CORDIC converter.
package rotate_pkg;

    localparam int HALF_W      = 16;              // one packed half-word (Q2.14 / Q3.13)
    localparam int XY_W        = 20;              // internal x/y, Q4.16
    localparam int Z_W         = 17;              // internal z, Q3.13 plus one guard bit
    localparam int CNT_W       = 4;               // micro-rotation counter
    localparam int PROD_W      = XY_W + HALF_W;   // x/y times INV_GAIN
    localparam int SCALE_SHIFT = 17;              // Q4.16 * Q1.15 -> Q2.14

    localparam logic signed [HALF_W-1:0] PI       = 16'sd25736;
    localparam logic signed [HALF_W-1:0] PI_HALF  = PI >>> 1;
    localparam logic signed [HALF_W-1:0] INV_GAIN = 16'sd19898;

    localparam logic signed [PROD_W-1:0] ROUND_BIAS = PROD_W'(1) << (SCALE_SHIFT - 1);
    localparam logic signed [PROD_W-1:0] SAT_MAX    = PROD_W'(32767);
    localparam logic signed [PROD_W-1:0] SAT_MIN    = PROD_W'(-32768);

    typedef enum logic [1:0] {IDLE, ROTATE, SCALE, DONE} state_t;

    // atan(2^-i) in Q3.13
    function automatic logic signed [Z_W-1:0] atan_lut(input logic [CNT_W-1:0] i);
        case (i)
            4'd0:    return 17'sd6434;
            4'd1:    return 17'sd3798;
            4'd2:    return 17'sd2007;
            4'd3:    return 17'sd1019;
            4'd4:    return 17'sd511;
            4'd5:    return 17'sd256;
            4'd6:    return 17'sd128;
            4'd7:    return 17'sd64;
            4'd8:    return 17'sd32;
            4'd9:    return 17'sd16;
            4'd10:   return 17'sd8;
            4'd11:   return 17'sd4;
            4'd12:   return 17'sd2;
            4'd13:   return 17'sd1;
            default: return 17'sd0;
        endcase
    endfunction

    // Round half-up from the gain-corrected product to Q2.14, clamping instead of wrapping.
    function automatic logic [HALF_W-1:0] round_sat(input logic signed [PROD_W-1:0] p);
        logic signed [PROD_W-1:0] r;
        r = (p + ROUND_BIAS) >>> SCALE_SHIFT;
        if (r > SAT_MAX)
            return 16'h7fff;
        else if (r < SAT_MIN)
            return 16'h8000;
        else
            return r[HALF_W-1:0];
    endfunction

endpackage

// File: rtl/rotate_cordic_rotate_lane.sv
// One CORDIC lane: quadrant pre-rotation on accept, one micro-rotation per ROTATE cycle,
// then gain correction with rounding and saturation into the output word.
module cordic_rotate_lane
    import rotate_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  state_t                state,
    input  logic                  accept,
    input  logic [CNT_W-1:0]      iter,
    input  logic [DATA_WIDTH-1:0] lane_in,
    output logic [DATA_WIDTH-1:0] lane_out
);

    logic signed [HALF_W-1:0] mag, phase;
    logic signed [XY_W-1:0]   mag_ext, x0, y0, x, y, x_shift, y_shift;
    logic signed [Z_W-1:0]    phase_ext, z0, z, atan_i;
    logic signed [PROD_W-1:0] x_prod, y_prod;

    assign mag       = lane_in[HALF_W-1:0];
    assign phase     = lane_in[2*HALF_W-1:HALF_W];
    assign mag_ext   = {{(XY_W-HALF_W-2){mag[HALF_W-1]}}, mag, 2'b00};
    assign phase_ext = {{(Z_W-HALF_W){phase[HALF_W-1]}}, phase};

    // Fold |phase| > pi/2 into the CORDIC convergence range with an exact 90-degree turn.
    always_comb begin
        x0 = mag_ext;
        y0 = '0;
        z0 = phase_ext;
        if (phase > PI_HALF) begin
            x0 = '0;
            y0 = mag_ext;
            z0 = phase_ext - Z_W'(PI_HALF);
        end else if (phase < -PI_HALF) begin
            x0 = '0;
            y0 = -mag_ext;
            z0 = phase_ext + Z_W'(PI_HALF);
        end
    end

    assign x_shift = x >>> iter;
    assign y_shift = y >>> iter;
    assign atan_i  = atan_lut(iter);
    assign x_prod  = PROD_W'(x) * PROD_W'(INV_GAIN);
    assign y_prod  = PROD_W'(y) * PROD_W'(INV_GAIN);

    // NOTE: x/y/z carry no reset; they are always loaded on accept before anything reads them.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            x <= x0;
            y <= y0;
            z <= z0;
        end else if (state == ROTATE) begin
            if (!z[Z_W-1]) begin
                x <= x - y_shift;
                y <= y + x_shift;
                z <= z - atan_i;
            end else begin
                x <= x + y_shift;
                y <= y - x_shift;
                z <= z + atan_i;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in)
            lane_out <= '0;
        else if (state == SCALE)
            lane_out <= {round_sat(y_prod), round_sat(x_prod)};
    end

endmodule

// File: rtl/rotate.sv
// Polar-to-rectangular converter: CHANNELS CORDIC lanes stepped in lock-step by one
// shared IDLE -> ROTATE -> SCALE -> DONE controller.
module rotate
    import rotate_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ITERATIONS = 14
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
    input  logic                           valid_in,
    output logic                           ready_out,
    output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
    output logic                           valid_out,
    input  logic                           ready_in
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] iter, iter_next;
    logic             accept;

    assign ready_out = (state == IDLE);
    assign valid_out = (state == DONE);
    assign accept    = ready_out && valid_in;

    // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
            iter  <= '0;
        end else begin
            state <= state_next;
            iter  <= iter_next;
        end
    end

    always_comb begin
        state_next = state;
        iter_next  = iter;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    state_next = ROTATE;
                    iter_next  = '0;
                end
            end
            ROTATE: begin
                if (iter == LAST_ITER)
                    state_next = SCALE;
                else
                    iter_next = iter + CNT_W'(1);
            end
            SCALE:   state_next = DONE;
            DONE:    if (ready_in) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lane
        cordic_rotate_lane #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_lane (
            .clk_in  (clk_in),
            .rst_n_in(rst_n_in),
            .state   (state),
            .accept  (accept),
            .iter    (iter),
            .lane_in (data_in[ch*DATA_WIDTH +: DATA_WIDTH]),
            .lane_out(data_out[ch*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_rotate.sv
// Self-checking bench for rotate: table-driven vectors and random beats feed a scoreboard
// queue; hand-written sequences cover latency, back-pressure, abort-by-reset and pacing.
module tb_rotate;

    localparam int CH = 4;
    localparam int DW = 32;
    localparam int IT = 14;
    localparam int NV = 5;

    typedef struct {
        logic [CH-1:0][15:0] mag;
        logic [CH-1:0][15:0] ph;
        logic [CH-1:0][15:0] ex;
        logic [CH-1:0][15:0] ey;
        int                  tol;
    } vec_t;

    logic             clk_in = 1'b0;
    logic             rst_n_in, valid_in, ready_in, ready_out, valid_out;
    logic [CH*DW-1:0] data_in, data_out;

    always #5 clk_in = ~clk_in;

    rotate #(.CHANNELS(CH), .DATA_WIDTH(DW), .ITERATIONS(IT)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .data_out (data_out),
        .valid_out(valid_out),
        .ready_in (ready_in)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   outputs = 0;
    vec_t tab[NV];
    vec_t cur;
    vec_t sb_q[$];
    int   accept_edges[$];

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp, input int tol);
        checks++;
        if (act - exp > tol || exp - act > tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    function automatic vec_t put(input vec_t v, input int l, input logic [15:0] m, p, x, y);
        v.mag[l] = m;
        v.ph[l]  = p;
        v.ex[l]  = x;
        v.ey[l]  = y;
        return v;
    endfunction

    function automatic logic [15:0] ideal(input logic [15:0] m, input logic [15:0] p, input bit sine);
        real r, a, v;
        int  q;
        r = $itor($signed(m));
        a = $itor($signed(p)) / 8192.0;
        v = sine ? r * $sin(a) : r * $cos(a);
        q = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return q[15:0];
    endfunction

    function automatic vec_t random_vec();
        vec_t v;
        for (int l = 0; l < CH; l++) begin
            logic [15:0] m, p;
            m = 16'($urandom_range(0, 32768) - 16384);
            p = 16'($urandom_range(0, 51472) - 25736);
            v = put(v, l, m, p, ideal(m, p, 1'b0), ideal(m, p, 1'b1));
        end
        v.tol = 4;
        return v;
    endfunction

    function automatic logic [CH*DW-1:0] pack(input vec_t v);
        logic [CH*DW-1:0] d;
        for (int l = 0; l < CH; l++) begin
            d[l*DW +: 16]      = v.mag[l];
            d[l*DW + 16 +: 16] = v.ph[l];
        end
        return d;
    endfunction

    // Scoreboard: push on an accept, pop and compare on a result handshake.
    always @(negedge clk_in) begin
        if (rst_n_in && valid_in && ready_out) begin
            sb_q.push_back(cur);
            accept_edges.push_back(cyc + 1);
        end
        if (rst_n_in && valid_out && ready_in) begin
            if (sb_q.size() == 0) begin
                check("unexpected result", 1, 0, 0);
            end else begin
                vec_t e;
                e = sb_q.pop_front();
                for (int l = 0; l < CH; l++) begin
                    logic signed [15:0] ax, ay, exs, eys;
                    ax  = data_out[l*DW +: 16];
                    ay  = data_out[l*DW + 16 +: 16];
                    exs = e.ex[l];
                    eys = e.ey[l];
                    check($sformatf("beat%0d lane%0d X", outputs, l), int'(ax), int'(exs), e.tol);
                    check($sformatf("beat%0d lane%0d Y", outputs, l), int'(ay), int'(eys), e.tol);
                end
            end
            outputs++;
        end
    end

    task automatic send(input vec_t v, output int acc);
        bit got;
        got = 1'b0;
        acc = -1;
        @(posedge clk_in);
        #1;
        cur      = v;
        data_in  = pack(v);
        valid_in = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_in);
            if (ready_out) begin
                acc = cyc + 1;
                got = 1'b1;
                break;
            end
        end
        if (!got) check("accept timeout", 0, 1, 0);
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 400; k++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk_in);
        end
        check("scoreboard drained", sb_q.size(), 0, 0);
    endtask

    task automatic wait_valid(output bit found);
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_in);
            if (valid_out) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int               acc, seen;
        bit               found;
        logic [CH*DW-1:0] held;

        rst_n_in = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        data_in  = '0;

        for (int l = 0; l < CH; l++) begin
            tab[0] = put(tab[0], l, 16'h4000, 16'h0000, 16'h4000, 16'h0000);
        end
        tab[0].tol = 4;
        tab[1] = put(tab[1], 0, 16'h4000, 16'd12868, 16'h0000, 16'h4000);
        tab[1] = put(tab[1], 1, 16'h4000, 16'd25736, 16'hC000, 16'h0000);
        tab[1] = put(tab[1], 2, 16'h4000, -16'sd6434, 16'h2D41, 16'hD2BF);
        tab[1] = put(tab[1], 3, 16'h4000, -16'sd12868, 16'h0000, 16'hC000);
        tab[1].tol = 4;
        tab[2] = put(tab[2], 0, 16'h0000, 16'd5000, 16'h0000, 16'h0000);
        tab[2] = put(tab[2], 1, 16'h0000, -16'sd20000, 16'h0000, 16'h0000);
        tab[2] = put(tab[2], 2, 16'h0000, 16'd25000, 16'h0000, 16'h0000);
        tab[2] = put(tab[2], 3, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tab[2].tol = 0;
        tab[3] = put(tab[3], 0, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000);
        tab[3] = put(tab[3], 1, 16'h8000, 16'h0000, 16'h8000, 16'h0000);
        tab[3] = put(tab[3], 2, 16'h7000, 16'd12868, 16'h0000, 16'h7000);
        tab[3] = put(tab[3], 3, 16'h9000, -16'sd12868, 16'h0000, 16'h7000);
        tab[3].tol = 16;
        tab[4] = put(tab[4], 0, 16'hC000, 16'd6434, 16'hD2BF, 16'hD2BF);
        tab[4] = put(tab[4], 1, 16'h2000, -16'sd25736, 16'hE000, 16'h0000);
        tab[4] = put(tab[4], 2, 16'hC000, 16'h0000, 16'hC000, 16'h0000);
        tab[4] = put(tab[4], 3, 16'h2D41, 16'd6434, 16'h2000, 16'h2000);
        tab[4].tol = 4;
        cur = tab[0];

        repeat (3) @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        @(negedge clk_in);
        check("reset ready_out", int'(ready_out), 1, 0);
        check("reset valid_out", int'(valid_out), 0, 0);
        check("reset data_out nonzero", int'(data_out != '0), 0, 0);

        // Latency of the first beat, counted in cycles after the accepting edge.
        send(tab[0], acc);
        wait_valid(found);
        check("latency cycles", found ? cyc - acc + 1 : -1, IT + 2, 0);
        drain();

        for (int i = 1; i < NV; i++) send(tab[i], acc);
        drain();

        // Back-pressure: result must hold while ready_in stays low.
        @(posedge clk_in);
        #1;
        ready_in = 1'b0;
        send(tab[1], acc);
        wait_valid(found);
        check("hold valid seen", int'(found), 1, 0);
        held = data_out;
        repeat (5) begin
            @(negedge clk_in);
            check("hold valid_out", int'(valid_out), 1, 0);
            check("hold ready_out", int'(ready_out), 0, 0);
            check("hold data changed", int'(data_out != held), 0, 0);
        end
        @(posedge clk_in);
        #1;
        ready_in = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        check("release valid_out", int'(valid_out), 0, 0);
        check("release ready_out", int'(ready_out), 1, 0);
        drain();

        // Reset lands on the edge that would run micro-rotation 5.
        send(tab[1], acc);
        repeat (5) @(posedge clk_in);
        #1;
        rst_n_in = 1'b0;
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        sb_q.delete();
        @(negedge clk_in);
        check("post-abort ready_out", int'(ready_out), 1, 0);
        check("post-abort data_out nonzero", int'(data_out != '0), 0, 0);
        seen = 0;
        repeat (25) begin
            @(negedge clk_in);
            if (valid_out) seen++;
        end
        check("aborted beat output count", seen, 0, 0);
        send(tab[4], acc);
        drain();

        // valid_in held high with fresh data every cycle: only every 17th beat is taken.
        accept_edges.delete();
        for (int k = 0; k < 60; k++) begin
            vec_t r;
            r = random_vec();
            @(posedge clk_in);
            #1;
            cur      = r;
            data_in  = pack(r);
            valid_in = 1'b1;
        end
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        drain();
        check("back-to-back accept count", accept_edges.size(), 4, 0);
        for (int i = 1; i < accept_edges.size(); i++)
            check($sformatf("accept spacing %0d", i), accept_edges[i] - accept_edges[i-1], IT + 3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
